// File: rtl/zap_mem_arbiter_if.sv
// Single-ported memory bus between zap_mem_arbiter (master) and the memory/bus fabric (slave).
interface zap_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_ben;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_ben, mem_wdata,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_ben, mem_wdata,
    output mem_ack, mem_rdata, mem_err
  );
endinterface

// File: rtl/zap_mem_arbiter.sv
// zap_mem_arbiter: serialises ZAP instruction-fetch and data accesses onto one memory bus.
// Bus errors and ack timeouts become instruction/data aborts.
// Build option ZAP_ARB_RR_EN: alternate grants on a fetch/data tie instead of data-first priority.
//
// state  | meaning
// IDLE   | sample core requests, pick a winner, latch its access
// GNT_I  | fetch access on the bus, waiting for ack or timeout
// GNT_D  | data access on the bus, waiting for ack or timeout
// RESP   | one-cycle response to the core (ivalid / dstall release / aborts)
module zap_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_iaddress,
  input  logic              i_ireq,
  output logic [31:0]       o_idata,
  output logic              o_ivalid,
  output logic              o_iabort,
  input  logic [ADDR_W-1:0] i_daddress,
  input  logic              i_drd_en,
  input  logic              i_dwr_en,
  input  logic [3:0]        i_dben,
  input  logic [31:0]       i_dwdata,
  output logic [31:0]       o_drdata,
  output logic              o_dstall,
  output logic              o_dabort,
  zap_mem_arbiter_if.master bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_GNT_I, S_GNT_D, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_ben;
  logic [31:0]       lat_wdata;
  logic              lat_wr;
  logic              gnt_d;
  logic [TMR_W-1:0]  timer;
  logic [31:0]       cap_data;
  logic              cap_err;
  logic [31:0]       idata_q;
  logic [31:0]       drdata_q;
  logic              d_pend;
  logic              any_req;
  logic              pick_d;
  logic              granted;
  logic              timer_done;
  logic              resp_i;
  logic              resp_d;

  assign d_pend     = i_drd_en | i_dwr_en;
  assign any_req    = d_pend | i_ireq;
  assign granted    = (state == S_GNT_I) || (state == S_GNT_D);
  assign timer_done = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign resp_i     = (state == S_RESP) && !gnt_d;
  assign resp_d     = (state == S_RESP) && gnt_d;

`ifdef ZAP_ARB_RR_EN
  // gnt_d always names the most recent grant (reset = fetch), so it doubles as last-grant
  assign pick_d = d_pend & (~i_ireq | ~gnt_d);
`else
  assign pick_d = d_pend;
`endif

  // state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // next-state: one bus access per grant, then a single response cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:           if (any_req) state_nxt = pick_d ? S_GNT_D : S_GNT_I;
      S_GNT_I, S_GNT_D: if (bus.mem_ack || timer_done) state_nxt = S_RESP;
      S_RESP:           state_nxt = S_IDLE;
      default:          state_nxt = S_IDLE;
    endcase
  end

  // latch the winning access in IDLE; run the timeout and capture the response while granted
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lat_addr  <= '0;
      lat_ben   <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      gnt_d     <= 1'b0;
      timer     <= '0;
      cap_data  <= '0;
      cap_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_d <= pick_d;
            timer <= '0;
            if (pick_d) begin
              lat_addr  <= i_daddress;
              lat_wr    <= i_dwr_en;
              lat_ben   <= i_dwr_en ? i_dben : 4'hF;
              lat_wdata <= i_dwdata;
            end else begin
              lat_addr <= i_iaddress;
              lat_wr   <= 1'b0;
              lat_ben  <= 4'hF;
            end
          end
        end
        S_GNT_I, S_GNT_D: begin
          timer <= timer + 1'b1;
          if (bus.mem_ack) begin
            cap_data <= bus.mem_rdata;
            cap_err  <= bus.mem_err;
          end else if (timer_done) begin
            // a timed-out access returns no data; report zero alongside the abort
            cap_data <= '0;
            cap_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // hold the last delivered instruction/load data between responses
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idata_q  <= '0;
      drdata_q <= '0;
    end else begin
      idata_q  <= o_idata;
      drdata_q <= o_drdata;
    end
  end

  assign bus.mem_req   = granted;
  assign bus.mem_wr    = lat_wr;
  assign bus.mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_ben   = lat_ben;
  assign bus.mem_wdata = lat_wdata;

  // core-side responses; a fetch is only delivered if the PC still points at it
  always_comb begin
    o_ivalid = resp_i && (lat_addr == i_iaddress);
    o_iabort = o_ivalid && cap_err;
    o_dabort = resp_d && cap_err;
    o_idata  = o_ivalid ? cap_data : idata_q;
    o_drdata = (resp_d && !lat_wr) ? cap_data : drdata_q;
    o_dstall = d_pend && !resp_d;
  end

endmodule
